// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mul_pkg;

  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone,
    StFix
  } state_e;

  // Counter must reach WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_datapath.sv
// Multiplicand/accumulator registers, the WIDTH-bit adder and the right shift.
// SEQ_MULTIPLIER_SIGNED_EN: capture operand magnitudes and the result sign on load.
module seq_mul_datapath
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               negate,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_in;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;
  assign neg_in = a[WIDTH-1] ^ b[WIDTH-1];
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign neg_in = 1'b0;
`endif

  // Upper half plus carry; the carry lands in the MSB after the shift.
  assign addend = acc_q[0] ? mcand_q : '0;
  assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    if (load) begin
      mcand_d = a_mag;
      acc_d   = {{WIDTH{1'b0}}, b_mag};
      neg_d   = neg_in;
    end else if (step) begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end else if (negate && neg_q) begin
      acc_d = -acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add WIDTH x WIDTH multiplier with valid/ready on both sides.
// SEQ_MULTIPLIER_SIGNED_EN: two's complement operands, extra FIX cycle for the sign.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] last_q, last_d;
  logic [2*WIDTH-1:0] acc;
  logic               load, step, negate;

  seq_mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .negate (negate),
    .a      (a),
    .b      (b),
    .acc    (acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    load    = 1'b0;
    step    = 1'b0;
    negate  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
          state_d = StFix;
`else
          state_d = StDone;
`endif
        end
      end
      StFix: begin
        negate  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        // Keep the retired result visible until the next one completes.
        if (out_ready) begin
          last_d  = acc;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign product   = (state_q == StDone) ? acc : last_q;

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised iterative shift-add multiplier for unsigned WIDTH x WIDTH operands, producing a 2*WIDTH-bit product. It uses one WIDTH-bit adder reused over WIDTH cycles, replacing the fixed 4x4 array of ripple-carry adders. It has valid/ready handshakes on both the operand side and the result side, so it drops into the team's datapaths alongside the existing adder blocks.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands A/B valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  result A*B
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, product=0, out_valid=0, busy=0, counter=0, internal registers=0. in_ready=1 once state is IDLE.
- FSM states:
  - IDLE -> CALC on in_valid && in_ready. On that edge, load the multiplicand register with a, load the low half of the accumulator with b, clear the upper half (WIDTH+1 bits including the carry), and set the counter to 0.
  - CALC: on each edge, if acc[0] is 1, add the multiplicand to acc[2W-1:W] with carry into the extra bit. Then shift the whole {carry, acc} right by 1 and increment the counter. After the WIDTH-th iteration, go to DONE.
  - DONE: out_valid=1 and product=acc, held stable while out_ready=0. On out_valid && out_ready, go to IDLE and set out_valid=0.
- Latency: out_valid rises after exactly WIDTH+1 rising edges counted from the accepting edge (load edge, then WIDTH iteration edges).
- Throughput: one product per WIDTH+2 cycles at best. in_ready is 0 in CALC and DONE. There is no same-cycle accept on the edge that retires a result; in_ready returns in the cycle after the handshake.
- product keeps the last result after leaving DONE and is overwritten only at the end of the next CALC.
- Changes to a/b while not accepted are ignored. Operands are captured only on the accept edge.
- No overflow is possible: 2*WIDTH bits holds the full range, e.g. (2^W-1)^2.
- Asynchronous reset mid-CALC or in DONE aborts the operation. The bench must see out_valid=0 immediately and no stale result afterward.

Optional Feature:
Macro SEQ_MULTIPLIER_SIGNED_EN.
- Defined: a and b are two's complement. On the accept edge, capture the magnitudes plus neg = a[W-1]^b[W-1]. Run the unsigned iteration. Then take one extra fix-up cycle (state FIX) that negates the accumulator if neg is set. Latency becomes WIDTH+2. -2^(W-1) * -2^(W-1) = +2^(2W-2) fits.
- Undefined: operands are unsigned, there is no FIX state, and latency is WIDTH+1.

Decomposition:
- Package seq_mul_pkg holds:
  - state enum (IDLE, CALC, DONE, FIX);
  - WIDTH_MAX=32 constant;
  - a function computing CNT_W.
- One sub-module, seq_mul_datapath, holds the multiplicand/accumulator registers, the WIDTH-bit adder and the shift. It is controlled by load/step/negate strobes from the FSM in seq_multiplier.

Test Plan:
1. WIDTH=4, a=15, b=15, out_ready=1 -> product=225 (0xE1), out_valid exactly 5 edges after accept, busy high throughout.
2. WIDTH=4, a=0, b=9, then a=9, b=0 -> product=0 both times. Then a=1, b=13 -> 13.
3. Backpressure: a=6, b=7, out_ready=0 for 10 cycles -> product=42 held stable, out_valid=1, in_ready=0 (a new in_valid is ignored). Raise out_ready -> one handshake, then in_ready=1 next cycle.
4. Reset mid-operation: accept a=11, b=13, pull rst_n low 2 cycles later -> out_valid=0 and in_ready=1 after release. Next op a=3, b=5 -> 15.
5. WIDTH=8 back-to-back 200 random pairs -> every product matches a*b, one result per 10 cycles with out_ready=1.
6. SEQ_MULTIPLIER_SIGNED_EN, WIDTH=4: (-8)*(-8) -> 64; (-8)*7 -> -56 (0xC8); 5*(-3) -> -15 (0xF1). Latency 6 edges.
